// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 16:1 single-bit mux.
// Optional hold timeout compiled in with MUX16_RR_TIMEOUT_EN (bounded by MAX_HOLD).
module mux16_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] req_i,
   input  logic        done_i,
   input  logic [15:0] in_i,
   output logic [3:0]  sel_o,
   output logic [15:0] grant_o,
   output logic        valid_o,
   output logic        out_o
);

   // state | meaning
   // IDLE  | no grant; search for next requester from ptr on each edge
   // BUSY  | grant held for sel until done, withdrawal or timeout

   typedef enum logic {IDLE, BUSY} state_t;

   if (MAX_HOLD < 1 || MAX_HOLD > 256) begin : g_bad_max_hold
      $error("MAX_HOLD out of range 1..256");
   end

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  sel_q, sel_d;
   logic [15:0] grant_q, grant_d;
   logic        valid_q, valid_d;
   logic [3:0]  pick, idx;
   logic        found;
   logic        rel;

`ifdef MUX16_RR_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0]  hold_q, hold_d;
`endif

   // First set request at or above ptr, wrapping 15 -> 0
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      idx   = ptr_q;
      for (int k = 0; k < 16; k++) begin
         idx = ptr_q + 4'(k);
         if (!found && req_i[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      rel = done_i | ~req_i[sel_q];
`ifdef MUX16_RR_TIMEOUT_EN
      rel = rel | (hold_q == HOLD_LAST);
`endif
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      valid_d = valid_q;
`ifdef MUX16_RR_TIMEOUT_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = pick;
               grant_d = 16'd1 << pick;
               valid_d = 1'b1;
               state_d = BUSY;
`ifdef MUX16_RR_TIMEOUT_EN
               hold_d  = 8'd0;
`endif
            end
         end
         BUSY: begin
            if (rel) begin
               valid_d = 1'b0;
               grant_d = 16'd0;
               ptr_d   = sel_q + 4'd1;
               state_d = IDLE;
            end else begin
`ifdef MUX16_RR_TIMEOUT_EN
               hold_d = hold_q + 8'd1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= 4'd0;
         sel_q   <= 4'd0;
         grant_q <= 16'd0;
         valid_q <= 1'b0;
`ifdef MUX16_RR_TIMEOUT_EN
         hold_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
`ifdef MUX16_RR_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   assign sel_o   = sel_q;
   assign grant_o = grant_q;
   assign valid_o = valid_q;
   assign out_o   = valid_q & in_i[sel_q];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Randomized and directed bench for mux16_rr_arbiter against a behavioural model.
module tb_mux16_rr_arbiter;

   localparam int MH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [15:0] req_i = 16'd0;
   logic        done_i = 1'b0;
   logic [15:0] in_i = 16'd0;
   logic [3:0]  sel_o;
   logic [15:0] grant_o;
   logic        valid_o;
   logic        out_o;

   int total = 0;
   int bad = 0;

   // reference model state
   int  m_ptr = 0;
   int  m_sel = 0;
   int  m_hold = 0;
   bit  m_busy = 0;

   mux16_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .done_i(done_i),
      .in_i(in_i), .sel_o(sel_o), .grant_o(grant_o), .valid_o(valid_o),
      .out_o(out_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input logic [15:0] rq, input bit d);
      bit rel;
      if (r) begin
         m_ptr = 0; m_sel = 0; m_hold = 0; m_busy = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < 16; k++) begin
            int i;
            i = (m_ptr + k) % 16;
            if (rq[i]) begin
               m_sel = i; m_busy = 1; m_hold = 0;
               break;
            end
         end
      end else begin
         rel = d || !rq[m_sel];
`ifdef MUX16_RR_TIMEOUT_EN
         if (m_hold == MH - 1) rel = 1;
`endif
         if (rel) begin
            m_busy = 0;
            m_ptr = (m_sel + 1) % 16;
         end else begin
            m_hold++;
         end
      end
   endtask

   task automatic cyc(input bit r, input logic [15:0] rq, input bit d, input logic [15:0] din);
      logic [15:0] eg;
      rst_i = r; req_i = rq; done_i = d; in_i = din;
      @(posedge clk_i);
      model_edge(r, rq, d);
      #1;
      eg = m_busy ? (16'd1 << m_sel) : 16'd0;
      chk("valid", {15'd0, valid_o}, {15'd0, m_busy});
      chk("grant", grant_o, eg);
      chk("sel", {12'd0, sel_o}, 16'(m_sel));
      chk("out", {15'd0, out_o}, {15'd0, (m_busy ? din[m_sel] : 1'b0)});
   endtask

   initial begin
      // reset and basic grant
      cyc(1, 16'h0000, 0, 16'h0000);
      cyc(1, 16'h0000, 0, 16'h0000);
      chk("rst_valid", {15'd0, valid_o}, 16'd0);
      chk("rst_grant", grant_o, 16'd0);
      cyc(0, 16'h0004, 0, 16'h3f0a);
      chk("basic_sel", {12'd0, sel_o}, 16'd2);
      chk("basic_grant", grant_o, 16'h0004);
      chk("basic_out", {15'd0, out_o}, 16'd0);
      cyc(0, 16'h0004, 1, 16'h3f0a);
      chk("basic_rel", {15'd0, valid_o}, 16'd0);

      // round robin 0 / 15 with wrap
      cyc(1, 16'h0000, 0, 16'h0000);
      for (int n = 0; n < 4; n++) begin
         cyc(0, 16'h8001, 0, 16'hffff);
         chk("rr_sel", {12'd0, sel_o}, (n % 2 == 0) ? 16'd0 : 16'd15);
         cyc(0, 16'h8001, 1, 16'hffff);
         chk("rr_bubble", {15'd0, valid_o}, 16'd0);
      end

      // withdrawal
      cyc(1, 16'h0000, 0, 16'h0000);
      cyc(0, 16'h1040, 0, 16'h0040);
      chk("wd_out", {15'd0, out_o}, 16'd1);
      cyc(0, 16'h1000, 0, 16'h0040);
      chk("wd_rel", {15'd0, valid_o}, 16'd0);
      cyc(0, 16'h1000, 0, 16'h0040);
      chk("wd_next", {12'd0, sel_o}, 16'hc);

      // long hold: timeout build releases every MH cycles, default build never
      cyc(1, 16'h0000, 0, 16'h0000);
      for (int n = 0; n < 100; n++) cyc(0, 16'h0003, 0, 16'h0001);
`ifndef MUX16_RR_TIMEOUT_EN
      chk("hold_still", {11'd0, valid_o, sel_o}, 16'h0010);
`endif

      // reset mid-grant, then simultaneous done + withdrawal
      cyc(1, 16'h0000, 0, 16'h0000);
      cyc(0, 16'h0200, 0, 16'h0000);
      chk("g9", {12'd0, sel_o}, 16'd9);
      cyc(1, 16'h0200, 0, 16'h0000);
      chk("midrst", {sel_o, 11'd0, valid_o}, 16'd0);
      cyc(0, 16'h0201, 0, 16'h0000);
      chk("from0", {12'd0, sel_o}, 16'd0);
      cyc(0, 16'h0000, 1, 16'h0000);
      cyc(0, 16'h0200, 0, 16'h0000);
      chk("g9b", {12'd0, sel_o}, 16'd9);
      cyc(0, 16'h0000, 1, 16'h0000);
      chk("simul_rel", {15'd0, valid_o}, 16'd0);
      cyc(0, 16'hffff, 0, 16'h0000);
      chk("ptr10", {12'd0, sel_o}, 16'd10);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] rq;
         rq = 16'($urandom);
         if ($urandom_range(0, 2) == 0) rq = rq & 16'($urandom);
         if ($urandom_range(0, 7) == 0) rq = 16'd0;
         cyc(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 4) == 0), 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter and select sequencer for the 16-to-1 single-bit multiplexer. Sixteen requesters share one mux output path. The block grants one requester at a time, drives the 4-bit mux select for the granted index, and presents that requester's data bit on a single output. It sits between the requesting sources and the consumer of the muxed bit. The mux datapath is instantiated inside this block.

## Interface

Parameters:
- MAX_HOLD, default 8: maximum grant length in cycles when the timeout is compiled in. Legal range 1..256.

Ports:
- clk — input, 1 bit: single clock. All state updates on the rising edge.
- rst — input, 1 bit: synchronous, active-high reset. Sampled on the rising edge of clk.
- req — input, 16 bits: request vector. Bit i high means requester i wants the mux.
- done — input, 1 bit: current grantee releases the mux. Ignored when idle.
- in — input, 16 bits: data bits. in[i] belongs to requester i.
- sel — output, 4 bits: registered select index. Drives the mux sel.
- grant — output, 16 bits: registered one-hot grant. Equals 1 << sel when valid, else 0.
- valid — output, 1 bit: registered. High while a grant is active.
- out — output, 1 bit: combinational. Equals in[sel] when valid, else 0.

## Operation

- Reset values (on any clk edge with rst=1):
  - sel=0, grant=0, valid=0.
  - Priority pointer ptr=0, hold counter=0, state IDLE.
- rst overrides everything, including mid-grant. The grant drops at that edge and ptr returns to 0.
- States: IDLE and BUSY.
- IDLE:
  - If req is nonzero, select the first set bit at or after ptr, searching upward and wrapping 15→0.
  - Register sel to that index, grant to the one-hot value, valid=1. Clear the hold counter and go to BUSY.
  - If req is zero, remain in IDLE with outputs at 0.
- BUSY: a release condition is any of the following, sampled at the edge:
  - done=1.
  - req[sel]=0 (requester withdrew).
  - With the timeout compiled in: the hold counter equals MAX_HOLD-1.
- On release:
  - valid=0, grant=0.
  - ptr = (sel+1) mod 16 (wraps 15→0).
  - Go to IDLE. sel keeps its last value.
- With no release, the hold counter increments by 1 each cycle.
- Simultaneous release conditions produce a single release.
- Changes to req bits other than the grantee's have no effect while BUSY.
- Fairness: a continuously requesting index i is granted within 16 grants.
- out path: a pure mux of in by sel, gated by valid. There is no registered stage.

## Timing

- Grant latency: req sampled at edge N gives grant, sel and valid visible after edge N. This is 1 cycle.
- Release latency: done or withdrawal sampled at edge M gives valid=0 after edge M.
- Mandatory one-cycle IDLE bubble between consecutive grants. The earliest next grant is after edge M+1.
- Minimum grant length is 1 cycle, when done=1 at the first edge after the grant.
- With the timeout enabled, the maximum grant length is exactly MAX_HOLD cycles.
- out follows in combinationally within the same cycle. It is valid whenever valid=1.

## Configuration

- Macro: MUX16_RR_TIMEOUT_EN.
- Defined:
  - The hold counter and the MAX_HOLD forced release are compiled in.
  - A requester holding req high without done is released after MAX_HOLD cycles. ptr then advances as for any release.
- Undefined:
  - No hold counter in the RTL and MAX_HOLD is unused.
  - The grant persists until done=1 or req[sel]=0, for unbounded length.

## Test plan

- Reset and basic grant: rst high for 2 cycles, then req=16'h0004, in=16'h3f0a.
  - One cycle later: sel=2, grant=16'h0004, valid=1, out=0.
  - done pulse → valid=0 the next cycle.
- Round-robin order: req=16'h8001 held, done pulsed each grant.
  - Grants alternate 0, 15, 0, 15.
  - ptr wraps 15→0 with one bubble cycle between grants.
- Withdrawal: grant index 6 with in=16'h0040 gives out=1.
  - Deassert req[6] → valid=0 the next cycle.
  - Next pending requester (req[12]) granted one cycle later with sel=4'hc.
- Timeout (MUX16_RR_TIMEOUT_EN defined, MAX_HOLD=4): req=16'h0003 held, done=0.
  - Index 0 is granted for exactly 4 cycles, then 1 bubble.
  - Index 1 is then granted for 4 cycles.
- No timeout (macro undefined): the same stimulus keeps index 0 granted for 100 cycles.
- Reset mid-grant and simultaneous events:
  - rst while BUSY on index 9 → all outputs 0 after that edge, and the next grant searches from 0.
  - done and withdrawal in the same cycle → exactly one release, with ptr=10.
